// File: rtl/janus_ref_pkg.sv
// Shared constants and FSM state type for the Janus reference-frequency monitor.
package janus_ref_pkg;

  localparam int NOMINAL_DEF      = 768;
  localparam int TOL_DEF          = 2;
  localparam int LOCK_COUNT_DEF   = 16;
  localparam int UNLOCK_COUNT_DEF = 4;
  localparam int TIMEOUT_DEF      = 1024;
  localparam int CNT_W            = 12;
  localparam int ERR_W            = 13;

  typedef enum logic [1:0] {
    NO_REF  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HOLD    = 2'd3
  } ref_state_t;

endpackage

// File: rtl/ref_edge_sync.sv
// Two-flop synchronizer for the asynchronous Ref_Div pin plus a registered
// rising-edge detector; the pulse is one Clk wide, three cycles after the pin edge.
module ref_edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic Ref_Div,
  output logic Ref_Edge
);

  logic sync_p0, sync_p1, sync_p2, edge_p3;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      edge_p3 <= 1'b0;
    end else begin
      sync_p0 <= Ref_Div;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      edge_p3 <= sync_p1 & ~sync_p2;
    end
  end

  assign Ref_Edge = edge_p3;

endmodule

// File: rtl/janus_ref_monitor.sv
// Measures the Ref_Div period in Clk cycles, reports the error against NOMINAL
// and qualifies reference presence and XO lock with a small hysteresis FSM.
module janus_ref_monitor
  import janus_ref_pkg::*;
#(
  parameter int NOMINAL      = NOMINAL_DEF,
  parameter int TOL          = TOL_DEF,
  parameter int LOCK_COUNT   = LOCK_COUNT_DEF,
  parameter int UNLOCK_COUNT = UNLOCK_COUNT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Ref_Div,
  output logic                    Ref_OK,
  output logic                    Lock_OK,
  output logic                    Tune_Sel,
  output logic signed [ERR_W-1:0] Period_Err,
  output logic                    Err_Valid
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);

  // Period is counter+1, so it needs one bit more than the counter.
  function automatic logic signed [ERR_W-1:0] period_error(input logic [CNT_W:0] period);
    int diff;
    diff = int'(period) - NOMINAL;
    return ERR_W'(diff);
  endfunction

  function automatic logic period_good(input logic signed [ERR_W-1:0] err);
    return (int'(err) >= -TOL) && (int'(err) <= TOL);
  endfunction

  logic              edge_p3;
  logic [CNT_W-1:0]  cnt_p4;
  logic [CNT_W:0]    period_p4;
  logic              have_meas;
  logic              timeout;
  ref_state_t        state, nxt_state;
  logic [GOOD_W-1:0] good_cnt, nxt_good;
  logic [BAD_W-1:0]  bad_cnt, nxt_bad;

  ref_edge_sync u_edge (
    .Clk      (Clk),
    .Reset    (Reset),
    .Ref_Div  (Ref_Div),
    .Ref_Edge (edge_p3)
  );

  assign period_p4 = {1'b0, cnt_p4} + (CNT_W + 1)'(1);
  assign timeout   = (cnt_p4 == CNT_W'(TIMEOUT - 1)) && !edge_p3;

  // Stage p4: period counter and error measurement
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_p4     <= '0;
      have_meas  <= 1'b0;
      Err_Valid  <= 1'b0;
      Period_Err <= '0;
    end else begin
      if (edge_p3)
        cnt_p4 <= '0;
      else if (cnt_p4 != '1)
        cnt_p4 <= cnt_p4 + CNT_W'(1);

      // The first edge after reset or loss of reference only opens a window.
      if (timeout)
        have_meas <= 1'b0;
      else if (edge_p3)
        have_meas <= 1'b1;

      Err_Valid <= edge_p3 && have_meas;
      if (edge_p3 && have_meas)
        Period_Err <= period_error(period_p4);
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_good  = good_cnt;
    nxt_bad   = bad_cnt;
    if (timeout) begin
      nxt_state = NO_REF;
      nxt_good  = '0;
      nxt_bad   = '0;
    end else begin
      case (state)
        NO_REF: begin
          if (edge_p3) begin
            nxt_state = ACQUIRE;
            nxt_good  = '0;
          end
        end
        ACQUIRE: begin
          if (Err_Valid) begin
            if (!period_good(Period_Err))
              nxt_good = '0;
            else if (int'(good_cnt) + 1 >= LOCK_COUNT) begin
              nxt_state = LOCKED;
              nxt_good  = '0;
            end else
              nxt_good = good_cnt + GOOD_W'(1);
          end
        end
        LOCKED: begin
          if (Err_Valid && !period_good(Period_Err)) begin
            nxt_state = HOLD;
            nxt_bad   = BAD_W'(1);
          end
        end
        HOLD: begin
          if (Err_Valid) begin
            if (period_good(Period_Err)) begin
              nxt_state = LOCKED;
              nxt_bad   = '0;
            end else if (int'(bad_cnt) + 1 >= UNLOCK_COUNT) begin
              nxt_state = ACQUIRE;
              nxt_good  = '0;
              nxt_bad   = '0;
            end else
              nxt_bad = bad_cnt + BAD_W'(1);
          end
        end
        default: nxt_state = NO_REF;
      endcase
    end
  end

  // Stage p5: state and its decoded outputs, registered together
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= NO_REF;
      good_cnt <= '0;
      bad_cnt  <= '0;
      Ref_OK   <= 1'b0;
      Lock_OK  <= 1'b0;
      Tune_Sel <= 1'b0;
    end else begin
      state    <= nxt_state;
      good_cnt <= nxt_good;
      bad_cnt  <= nxt_bad;
      Ref_OK   <= (nxt_state != NO_REF);
      Lock_OK  <= (nxt_state == LOCKED) || (nxt_state == HOLD);
      Tune_Sel <= (nxt_state != NO_REF);
    end
  end

endmodule

// File: tb/tb_janus_ref_monitor.sv
// Scoreboard bench for janus_ref_monitor: directed Ref_Div periods push the
// expected error/lock pairs; a negedge monitor pops them on every Err_Valid.
module tb_janus_ref_monitor;

  localparam int NOM = 768;
  localparam int TMO = 1024;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Ref_Div;
  logic              Ref_OK, Lock_OK, Tune_Sel, Err_Valid;
  logic signed [12:0] Period_Err;

  typedef struct {
    int err;
    bit lock;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_last = 0;
  int   prev_n = 0;
  bit   have_prev = 0;
  bit   lock_chk = 0;
  bit   lock_exp = 0;

  janus_ref_monitor dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Ref_Div    (Ref_Div),
    .Ref_OK     (Ref_OK),
    .Lock_OK    (Lock_OK),
    .Tune_Sel   (Tune_Sel),
    .Period_Err (Period_Err),
    .Err_Valid  (Err_Valid)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rising pin edge now, next one n cycles later; this edge carries the
  // measurement of the previous period, if there was one.
  task automatic ref_period(input int n, input bit exp_lock);
    exp_t e;
    if (have_prev) begin
      e.err  = prev_n - NOM;
      e.lock = exp_lock;
      q.push_back(e);
    end
    t_last  = cyc + 1;
    Ref_Div = 1'b1;
    repeat (n / 2) @(negedge Clk);
    Ref_Div = 1'b0;
    repeat (n - n / 2) @(negedge Clk);
    prev_n    = n;
    have_prev = 1'b1;
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (lock_chk) begin
      chk("lock_after_strobe", int'(Lock_OK), int'(lock_exp));
      chk("ref_ok_after_strobe", int'(Ref_OK), 1);
      chk("tune_sel_after_strobe", int'(Tune_Sel), 1);
      lock_chk = 1'b0;
    end
    if (Err_Valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: Period_Err %0d with no strobe expected (cycle %0d)",
                 Period_Err, cyc);
      end else begin
        e = q.pop_front();
        chk("period_err", int'(Period_Err), e.err);
        lock_exp = e.lock;
        lock_chk = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  int b_n[11] = '{1024, 768, 760, 760, 760, 768, 760, 760, 760, 760, 768};
  bit b_l[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int a_n[6]  = '{771, 768, 771, 768, 771, 768};

  initial begin
    int guard;
    Reset   = 1'b1;
    Ref_Div = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_ref_ok", int'(Ref_OK), 0);
    chk("rst_lock_ok", int'(Lock_OK), 0);
    chk("rst_tune_sel", int'(Tune_Sel), 0);
    chk("rst_err_valid", int'(Err_Valid), 0);
    chk("rst_period_err", int'(Period_Err), 0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    // 20 nominal edges: lock after the 16th good strobe (edge 17)
    t_last  = cyc + 1;
    Ref_Div = 1'b1;
    repeat (10) @(negedge Clk);
    chk("ref_ok_after_edge1", int'(Ref_OK), 1);
    chk("lock_ok_after_edge1", int'(Lock_OK), 0);
    repeat (374) @(negedge Clk);
    Ref_Div = 1'b0;
    repeat (384) @(negedge Clk);
    prev_n    = 768;
    have_prev = 1'b1;
    for (int k = 2; k <= 20; k++) ref_period(768, k >= 17);

    // Edge exactly on the timeout cycle, then HOLD excursions and unlock
    for (int i = 0; i < 11; i++) ref_period(b_n[i], b_l[i]);

    // Alternating 768/771 never locks, then relock with 16 good periods
    for (int i = 0; i < 6; i++) ref_period(a_n[i], 1'b0);
    for (int i = 0; i < 15; i++) ref_period(768, 1'b0);
    ref_period(1020, 1'b1);

    // Ref_Div held low: outputs fall TIMEOUT+1 cycles after the pulse
    guard = 0;
    while (cyc < t_last + TMO + 2 && guard < 3000) begin
      @(negedge Clk);
      guard++;
    end
    chk("timeout_wait_bound", int'(cyc == t_last + TMO + 2), 1);
    chk("pre_timeout_ref_ok", int'(Ref_OK), 1);
    chk("pre_timeout_lock_ok", int'(Lock_OK), 1);
    @(negedge Clk);
    chk("timeout_ref_ok", int'(Ref_OK), 0);
    chk("timeout_lock_ok", int'(Lock_OK), 0);
    chk("timeout_tune_sel", int'(Tune_Sel), 0);
    have_prev = 1'b0;

    // 5000-cycle periods: each edge only re-opens ACQUIRE, then times out
    for (int i = 0; i < 2; i++) begin
      Ref_Div = 1'b1;
      repeat (10) @(negedge Clk);
      chk("slow_ref_ok_after_edge", int'(Ref_OK), 1);
      repeat (2490) @(negedge Clk);
      Ref_Div = 1'b0;
      repeat (2500) @(negedge Clk);
    end
    chk("slow_ref_ok_end", int'(Ref_OK), 0);
    chk("slow_lock_ok_end", int'(Lock_OK), 0);

    // Relock, then reset mid-period during the low half
    ref_period(768, 1'b0);
    for (int i = 0; i < 15; i++) ref_period(768, 1'b0);
    ref_period(500, 1'b1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_ref_ok", int'(Ref_OK), 0);
    chk("midrst_lock_ok", int'(Lock_OK), 0);
    chk("midrst_tune_sel", int'(Tune_Sel), 0);
    chk("midrst_err_valid", int'(Err_Valid), 0);
    chk("midrst_period_err", int'(Period_Err), 0);
    Reset     = 1'b0;
    have_prev = 1'b0;
    repeat (300) @(negedge Clk);
    ref_period(768, 1'b0);
    ref_period(768, 1'b0);
    repeat (20) @(negedge Clk);
    chk("post_reset_ref_ok", int'(Ref_OK), 1);
    chk("post_reset_lock_ok", int'(Lock_OK), 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
